busarb: RTL and testbench

Two-port AXI4 master arbiter. It shares one external AXI4 master port between two CPU-side memory masters: S0 is the data memory unit, S1 is the instruction memory unit. Read (AR/R) and write (AW/W/B) paths are arbitrated independently with round-robin fairness. A grant is held for a whole transaction, including bursts, so requesters never interleave.

---
 rtl/busarb.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_busarb.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/busarb.sv
// -----------------------------------------------------------------------------
// busarb -- two-port AXI4 master arbiter.
//
// Purpose:
//   Shares one external AXI4 master port between two CPU-side masters
//   (S0 = data memory unit, S1 = instruction memory unit). The read path
//   (AR/R) and the write path (AW/W/B) each have their own round-robin
//   arbiter and FSM. A grant is held for a whole transaction, bursts
//   included, so the two requesters never interleave on a path. After the
//   one-cycle arbitration step all forwarding is purely combinational.
//
// Ports:
//   CLK, RST            single clock; synchronous active-high reset
//   S0_AXI_*, S1_AXI_*  CPU-side slave ports (AR/R and AW/W/B channels)
//   M_AXI_*             external master port; AR/AW side-band fields are
//                       driven with constants, RID/BID/RUSER/BUSER ignored
// -----------------------------------------------------------------------------
module busarb #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                              CLK,
    input  logic                              RST,
    // S0 read
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     S0_AXI_ARADDR,
    input  logic [7:0]                        S0_AXI_ARLEN,
    input  logic                              S0_AXI_ARVALID,
    output logic                              S0_AXI_ARREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     S0_AXI_RDATA,
    output logic [1:0]                        S0_AXI_RRESP,
    output logic                              S0_AXI_RLAST,
    output logic                              S0_AXI_RVALID,
    input  logic                              S0_AXI_RREADY,
    // S0 write
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     S0_AXI_AWADDR,
    input  logic [7:0]                        S0_AXI_AWLEN,
    input  logic                              S0_AXI_AWVALID,
    output logic                              S0_AXI_AWREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     S0_AXI_WDATA,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   S0_AXI_WSTRB,
    input  logic                              S0_AXI_WLAST,
    input  logic                              S0_AXI_WVALID,
    output logic                              S0_AXI_WREADY,
    output logic [1:0]                        S0_AXI_BRESP,
    output logic                              S0_AXI_BVALID,
    input  logic                              S0_AXI_BREADY,
    // S1 read
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     S1_AXI_ARADDR,
    input  logic [7:0]                        S1_AXI_ARLEN,
    input  logic                              S1_AXI_ARVALID,
    output logic                              S1_AXI_ARREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     S1_AXI_RDATA,
    output logic [1:0]                        S1_AXI_RRESP,
    output logic                              S1_AXI_RLAST,
    output logic                              S1_AXI_RVALID,
    input  logic                              S1_AXI_RREADY,
    // S1 write
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     S1_AXI_AWADDR,
    input  logic [7:0]                        S1_AXI_AWLEN,
    input  logic                              S1_AXI_AWVALID,
    output logic                              S1_AXI_AWREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     S1_AXI_WDATA,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   S1_AXI_WSTRB,
    input  logic                              S1_AXI_WLAST,
    input  logic                              S1_AXI_WVALID,
    output logic                              S1_AXI_WREADY,
    output logic [1:0]                        S1_AXI_BRESP,
    output logic                              S1_AXI_BVALID,
    input  logic                              S1_AXI_BREADY,
    // M read address
    output logic [0:0]                        M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [7:0]                        M_AXI_ARLEN,
    output logic [2:0]                        M_AXI_ARSIZE,
    output logic [1:0]                        M_AXI_ARBURST,
    output logic                              M_AXI_ARLOCK,
    output logic [3:0]                        M_AXI_ARCACHE,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic [3:0]                        M_AXI_ARQOS,
    output logic [0:0]                        M_AXI_ARUSER,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    // M read data
    input  logic [0:0]                        M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RLAST,
    input  logic [0:0]                        M_AXI_RUSER,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY,
    // M write address
    output logic [0:0]                        M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWLOCK,
    output logic [3:0]                        M_AXI_AWCACHE,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic [3:0]                        M_AXI_AWQOS,
    output logic [0:0]                        M_AXI_AWUSER,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    // M write data
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic [0:0]                        M_AXI_WUSER,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    // M write response
    input  logic [0:0]                        M_AXI_BID,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic [0:0]                        M_AXI_BUSER,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY
);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_e;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_XFER = 2'd1, W_RESP = 2'd2} wr_state_e;

    rd_state_e rstate_q, rstate_d;
    wr_state_e wstate_q, wstate_d;
    logic      rgnt_q, rgnt_d;      // 0 = S0, 1 = S1
    logic      wgnt_q, wgnt_d;
    logic      rprio_q, rprio_d;    // port served last on the read path
    logic      wprio_q, wprio_d;    // port served last on the write path
    logic      aw_done_q, aw_done_d;
    logic      w_done_q, w_done_d;

    // Round-robin pick: a lone requester wins; on a tie the port that was
    // not served last wins.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        if (req0 && req1) return ~last;
        return req1;
    endfunction

    // ---------------------------------------------------------------------
    // Constant side-band fields
    // ---------------------------------------------------------------------
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = '0;
    assign M_AXI_ARQOS   = '0;
    assign M_AXI_ARUSER  = '0;
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWSIZE  = 3'b010;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = '0;
    assign M_AXI_AWQOS   = '0;
    assign M_AXI_AWUSER  = '0;
    assign M_AXI_WUSER   = '0;

    logic unused_inputs;
    assign unused_inputs = ^{M_AXI_RID, M_AXI_BID, M_AXI_RUSER, M_AXI_BUSER};

    // ---------------------------------------------------------------------
    // Read path forwarding: phase enables gate every muxed output so that
    // idle / wrong-phase cycles present zero payload and zero handshakes.
    // ---------------------------------------------------------------------
    logic ar_fwd, r_fwd;
    assign ar_fwd = (rstate_q == R_ADDR);
    assign r_fwd  = (rstate_q == R_DATA);

    assign M_AXI_ARADDR  = ar_fwd ? (rgnt_q ? S1_AXI_ARADDR : S0_AXI_ARADDR) : '0;
    assign M_AXI_ARLEN   = ar_fwd ? (rgnt_q ? S1_AXI_ARLEN  : S0_AXI_ARLEN)  : '0;
    assign M_AXI_ARVALID = ar_fwd & (rgnt_q ? S1_AXI_ARVALID : S0_AXI_ARVALID);
    assign S0_AXI_ARREADY = ar_fwd & ~rgnt_q & M_AXI_ARREADY;
    assign S1_AXI_ARREADY = ar_fwd &  rgnt_q & M_AXI_ARREADY;

    assign M_AXI_RREADY  = r_fwd & (rgnt_q ? S1_AXI_RREADY : S0_AXI_RREADY);
    assign S0_AXI_RVALID = r_fwd & ~rgnt_q & M_AXI_RVALID;
    assign S1_AXI_RVALID = r_fwd &  rgnt_q & M_AXI_RVALID;
    assign S0_AXI_RDATA  = (r_fwd & ~rgnt_q) ? M_AXI_RDATA : '0;
    assign S1_AXI_RDATA  = (r_fwd &  rgnt_q) ? M_AXI_RDATA : '0;
    assign S0_AXI_RRESP  = (r_fwd & ~rgnt_q) ? M_AXI_RRESP : '0;
    assign S1_AXI_RRESP  = (r_fwd &  rgnt_q) ? M_AXI_RRESP : '0;
    assign S0_AXI_RLAST  = r_fwd & ~rgnt_q & M_AXI_RLAST;
    assign S1_AXI_RLAST  = r_fwd &  rgnt_q & M_AXI_RLAST;

    // ---------------------------------------------------------------------
    // Write path forwarding. AW and W are forwarded independently until
    // their own handshake completes, so a finished channel is not replayed
    // while the other one is still waiting.
    // ---------------------------------------------------------------------
    logic aw_fwd, w_fwd, b_fwd;
    assign aw_fwd = (wstate_q == W_XFER) & ~aw_done_q;
    assign w_fwd  = (wstate_q == W_XFER) & ~w_done_q;
    assign b_fwd  = (wstate_q == W_RESP);

    assign M_AXI_AWADDR  = aw_fwd ? (wgnt_q ? S1_AXI_AWADDR : S0_AXI_AWADDR) : '0;
    assign M_AXI_AWLEN   = aw_fwd ? (wgnt_q ? S1_AXI_AWLEN  : S0_AXI_AWLEN)  : '0;
    assign M_AXI_AWVALID = aw_fwd & (wgnt_q ? S1_AXI_AWVALID : S0_AXI_AWVALID);
    assign S0_AXI_AWREADY = aw_fwd & ~wgnt_q & M_AXI_AWREADY;
    assign S1_AXI_AWREADY = aw_fwd &  wgnt_q & M_AXI_AWREADY;

    assign M_AXI_WDATA   = w_fwd ? (wgnt_q ? S1_AXI_WDATA : S0_AXI_WDATA) : '0;
    assign M_AXI_WSTRB   = w_fwd ? (wgnt_q ? S1_AXI_WSTRB : S0_AXI_WSTRB) : '0;
    assign M_AXI_WLAST   = w_fwd & (wgnt_q ? S1_AXI_WLAST  : S0_AXI_WLAST);
    assign M_AXI_WVALID  = w_fwd & (wgnt_q ? S1_AXI_WVALID : S0_AXI_WVALID);
    assign S0_AXI_WREADY = w_fwd & ~wgnt_q & M_AXI_WREADY;
    assign S1_AXI_WREADY = w_fwd &  wgnt_q & M_AXI_WREADY;

    assign M_AXI_BREADY  = b_fwd & (wgnt_q ? S1_AXI_BREADY : S0_AXI_BREADY);
    assign S0_AXI_BVALID = b_fwd & ~wgnt_q & M_AXI_BVALID;
    assign S1_AXI_BVALID = b_fwd &  wgnt_q & M_AXI_BVALID;
    assign S0_AXI_BRESP  = (b_fwd & ~wgnt_q) ? M_AXI_BRESP : '0;
    assign S1_AXI_BRESP  = (b_fwd &  wgnt_q) ? M_AXI_BRESP : '0;

    // ---------------------------------------------------------------------
    // Read FSM next state
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        rstate_d = rstate_q;
        rgnt_d   = rgnt_q;
        rprio_d  = rprio_q;
        case (rstate_q)
            R_IDLE: begin
                if (S0_AXI_ARVALID || S1_AXI_ARVALID) begin
                    rgnt_d   = rr_pick(S0_AXI_ARVALID, S1_AXI_ARVALID, rprio_q);
                    rstate_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (M_AXI_ARVALID && M_AXI_ARREADY) rstate_d = R_DATA;
            end
            R_DATA: begin
                if (M_AXI_RVALID && M_AXI_RREADY && M_AXI_RLAST) begin
                    rstate_d = R_IDLE;
                    rprio_d  = rgnt_q;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Write FSM next state
    // ---------------------------------------------------------------------
    logic aw_hs, w_last_hs;
    assign aw_hs     = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_last_hs = M_AXI_WVALID & M_AXI_WREADY & M_AXI_WLAST;

    always_comb begin
        wstate_d  = wstate_q;
        wgnt_d    = wgnt_q;
        wprio_d   = wprio_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (wstate_q)
            W_IDLE: begin
                if (S0_AXI_AWVALID || S1_AXI_AWVALID) begin
                    wgnt_d   = rr_pick(S0_AXI_AWVALID, S1_AXI_AWVALID, wprio_q);
                    wstate_d = W_XFER;
                end
            end
            W_XFER: begin
                // Leave as soon as both halves are done, counting a handshake
                // that lands in this very cycle; the flags restart clear.
                if ((aw_done_q || aw_hs) && (w_done_q || w_last_hs)) begin
                    wstate_d  = W_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_done_q | aw_hs;
                    w_done_d  = w_done_q | w_last_hs;
                end
            end
            W_RESP: begin
                if (M_AXI_BVALID && M_AXI_BREADY) begin
                    wstate_d = W_IDLE;
                    wprio_d  = wgnt_q;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers. Priority resets to S1 so S0 wins the first tie.
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge value of its inputs, independent of statement order.
        if (RST) begin
            rstate_q  <= R_IDLE;
            rgnt_q    <= 1'b0;
            rprio_q   <= 1'b1;
            wstate_q  <= W_IDLE;
            wgnt_q    <= 1'b0;
            wprio_q   <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            rstate_q  <= rstate_d;
            rgnt_q    <= rgnt_d;
            rprio_q   <= rprio_d;
            wstate_q  <= wstate_d;
            wgnt_q    <= wgnt_d;
            wprio_q   <= wprio_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_busarb.sv
// -----------------------------------------------------------------------------
// tb_busarb -- directed self-checking bench for busarb.
// Inputs are driven 1 ns after the rising edge and outputs are sampled 1 ns
// later, well away from the next rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_busarb;

    logic        CLK = 1'b0;
    logic        RST;

    logic [31:0] S0_AXI_ARADDR, S1_AXI_ARADDR;
    logic [7:0]  S0_AXI_ARLEN, S1_AXI_ARLEN;
    logic        S0_AXI_ARVALID, S1_AXI_ARVALID;
    logic        S0_AXI_ARREADY, S1_AXI_ARREADY;
    logic [31:0] S0_AXI_RDATA, S1_AXI_RDATA;
    logic [1:0]  S0_AXI_RRESP, S1_AXI_RRESP;
    logic        S0_AXI_RLAST, S1_AXI_RLAST;
    logic        S0_AXI_RVALID, S1_AXI_RVALID;
    logic        S0_AXI_RREADY, S1_AXI_RREADY;
    logic [31:0] S0_AXI_AWADDR, S1_AXI_AWADDR;
    logic [7:0]  S0_AXI_AWLEN, S1_AXI_AWLEN;
    logic        S0_AXI_AWVALID, S1_AXI_AWVALID;
    logic        S0_AXI_AWREADY, S1_AXI_AWREADY;
    logic [31:0] S0_AXI_WDATA, S1_AXI_WDATA;
    logic [3:0]  S0_AXI_WSTRB, S1_AXI_WSTRB;
    logic        S0_AXI_WLAST, S1_AXI_WLAST;
    logic        S0_AXI_WVALID, S1_AXI_WVALID;
    logic        S0_AXI_WREADY, S1_AXI_WREADY;
    logic [1:0]  S0_AXI_BRESP, S1_AXI_BRESP;
    logic        S0_AXI_BVALID, S1_AXI_BVALID;
    logic        S0_AXI_BREADY, S1_AXI_BREADY;

    logic [0:0]  M_AXI_ARID, M_AXI_ARUSER, M_AXI_AWID, M_AXI_AWUSER, M_AXI_WUSER;
    logic [31:0] M_AXI_ARADDR, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_RDATA;
    logic [7:0]  M_AXI_ARLEN, M_AXI_AWLEN;
    logic [2:0]  M_AXI_ARSIZE, M_AXI_AWSIZE, M_AXI_ARPROT, M_AXI_AWPROT;
    logic [1:0]  M_AXI_ARBURST, M_AXI_AWBURST, M_AXI_RRESP, M_AXI_BRESP;
    logic        M_AXI_ARLOCK, M_AXI_AWLOCK;
    logic [3:0]  M_AXI_ARCACHE, M_AXI_AWCACHE, M_AXI_ARQOS, M_AXI_AWQOS, M_AXI_WSTRB;
    logic        M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_AWVALID, M_AXI_AWREADY;
    logic        M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
    logic [0:0]  M_AXI_RID, M_AXI_RUSER, M_AXI_BID, M_AXI_BUSER;
    logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
    logic        M_AXI_BVALID, M_AXI_BREADY;

    int n_cmp = 0;
    int n_err = 0;

    busarb dut (
        .CLK(CLK), .RST(RST),
        .S0_AXI_ARADDR(S0_AXI_ARADDR), .S0_AXI_ARLEN(S0_AXI_ARLEN), .S0_AXI_ARVALID(S0_AXI_ARVALID),
        .S0_AXI_ARREADY(S0_AXI_ARREADY), .S0_AXI_RDATA(S0_AXI_RDATA), .S0_AXI_RRESP(S0_AXI_RRESP),
        .S0_AXI_RLAST(S0_AXI_RLAST), .S0_AXI_RVALID(S0_AXI_RVALID), .S0_AXI_RREADY(S0_AXI_RREADY),
        .S0_AXI_AWADDR(S0_AXI_AWADDR), .S0_AXI_AWLEN(S0_AXI_AWLEN), .S0_AXI_AWVALID(S0_AXI_AWVALID),
        .S0_AXI_AWREADY(S0_AXI_AWREADY), .S0_AXI_WDATA(S0_AXI_WDATA), .S0_AXI_WSTRB(S0_AXI_WSTRB),
        .S0_AXI_WLAST(S0_AXI_WLAST), .S0_AXI_WVALID(S0_AXI_WVALID), .S0_AXI_WREADY(S0_AXI_WREADY),
        .S0_AXI_BRESP(S0_AXI_BRESP), .S0_AXI_BVALID(S0_AXI_BVALID), .S0_AXI_BREADY(S0_AXI_BREADY),
        .S1_AXI_ARADDR(S1_AXI_ARADDR), .S1_AXI_ARLEN(S1_AXI_ARLEN), .S1_AXI_ARVALID(S1_AXI_ARVALID),
        .S1_AXI_ARREADY(S1_AXI_ARREADY), .S1_AXI_RDATA(S1_AXI_RDATA), .S1_AXI_RRESP(S1_AXI_RRESP),
        .S1_AXI_RLAST(S1_AXI_RLAST), .S1_AXI_RVALID(S1_AXI_RVALID), .S1_AXI_RREADY(S1_AXI_RREADY),
        .S1_AXI_AWADDR(S1_AXI_AWADDR), .S1_AXI_AWLEN(S1_AXI_AWLEN), .S1_AXI_AWVALID(S1_AXI_AWVALID),
        .S1_AXI_AWREADY(S1_AXI_AWREADY), .S1_AXI_WDATA(S1_AXI_WDATA), .S1_AXI_WSTRB(S1_AXI_WSTRB),
        .S1_AXI_WLAST(S1_AXI_WLAST), .S1_AXI_WVALID(S1_AXI_WVALID), .S1_AXI_WREADY(S1_AXI_WREADY),
        .S1_AXI_BRESP(S1_AXI_BRESP), .S1_AXI_BVALID(S1_AXI_BVALID), .S1_AXI_BREADY(S1_AXI_BREADY),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
        .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
        .M_AXI_ARUSER(M_AXI_ARUSER), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RUSER(M_AXI_RUSER), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
        .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
        .M_AXI_AWUSER(M_AXI_AWUSER), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WUSER(M_AXI_WUSER), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BUSER(M_AXI_BUSER),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
    );

    always #5 CLK = ~CLK;

    // Every handshake output of the arbiter, packed for "all quiet" checks.
    function automatic logic [14:0] hs_vec();
        return {M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_RREADY, M_AXI_BREADY,
                S0_AXI_ARREADY, S1_AXI_ARREADY, S0_AXI_AWREADY, S1_AXI_AWREADY,
                S0_AXI_WREADY, S1_AXI_WREADY, S0_AXI_RVALID, S1_AXI_RVALID,
                S0_AXI_BVALID, S1_AXI_BVALID};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        S0_AXI_ARADDR = '0; S0_AXI_ARLEN = '0; S0_AXI_ARVALID = 0; S0_AXI_RREADY = 0;
        S1_AXI_ARADDR = '0; S1_AXI_ARLEN = '0; S1_AXI_ARVALID = 0; S1_AXI_RREADY = 0;
        S0_AXI_AWADDR = '0; S0_AXI_AWLEN = '0; S0_AXI_AWVALID = 0;
        S0_AXI_WDATA = '0; S0_AXI_WSTRB = '0; S0_AXI_WLAST = 0; S0_AXI_WVALID = 0; S0_AXI_BREADY = 0;
        S1_AXI_AWADDR = '0; S1_AXI_AWLEN = '0; S1_AXI_AWVALID = 0;
        S1_AXI_WDATA = '0; S1_AXI_WSTRB = '0; S1_AXI_WLAST = 0; S1_AXI_WVALID = 0; S1_AXI_BREADY = 0;
        M_AXI_ARREADY = 0; M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
        M_AXI_RID = '0; M_AXI_RDATA = '0; M_AXI_RRESP = '0; M_AXI_RLAST = 0; M_AXI_RUSER = '0; M_AXI_RVALID = 0;
        M_AXI_BID = '0; M_AXI_BRESP = '0; M_AXI_BUSER = '0; M_AXI_BVALID = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1;
        tick();
        tick();
        RST = 0;
    endtask

    task automatic test_reset();
        do_reset();
        // Slave-side readies/valids high and a payload present without VALID:
        // an idle arbiter must still show nothing.
        M_AXI_ARREADY = 1; M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
        M_AXI_RVALID = 1; M_AXI_BVALID = 1; M_AXI_RDATA = 32'hCAFE0001;
        S0_AXI_RREADY = 1; S1_AXI_RREADY = 1; S0_AXI_BREADY = 1; S1_AXI_BREADY = 1;
        S0_AXI_ARADDR = 32'h1234;
        settle();
        n_cmp++; if (hs_vec() !== 15'h0) begin n_err++; $display("FAIL reset_handshakes: got %h want %h", hs_vec(), 15'h0); end
        n_cmp++; if (M_AXI_ARADDR !== 32'h0) begin n_err++; $display("FAIL reset_araddr: got %h want %h", M_AXI_ARADDR, 32'h0); end
        n_cmp++; if (S0_AXI_RDATA !== 32'h0) begin n_err++; $display("FAIL reset_s0_rdata: got %h want %h", S0_AXI_RDATA, 32'h0); end
        n_cmp++; if ({M_AXI_ARCACHE, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_AWCACHE} !== {4'b0011, 3'b010, 2'b01, 4'b0011}) begin
            n_err++; $display("FAIL const_fields: got %h want %h", {M_AXI_ARCACHE, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_AWCACHE}, {4'b0011, 3'b010, 2'b01, 4'b0011});
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_single_read();
        do_reset();
        S0_AXI_ARADDR = 32'h1000; S0_AXI_ARLEN = 8'd0; S0_AXI_ARVALID = 1;
        settle();
        n_cmp++; if (M_AXI_ARVALID !== 1'b0) begin n_err++; $display("FAIL sr_arb_cycle_arvalid: got %b want 0", M_AXI_ARVALID); end
        tick();
        n_cmp++; if ({M_AXI_ARVALID, M_AXI_ARADDR, S0_AXI_ARREADY} !== {1'b1, 32'h1000, 1'b0}) begin
            n_err++; $display("FAIL sr_ar_forward: got %h want %h", {M_AXI_ARVALID, M_AXI_ARADDR, S0_AXI_ARREADY}, {1'b1, 32'h1000, 1'b0});
        end
        M_AXI_ARREADY = 1;
        settle();
        n_cmp++; if ({S0_AXI_ARREADY, S1_AXI_ARREADY} !== 2'b10) begin n_err++; $display("FAIL sr_arready: got %b want 10", {S0_AXI_ARREADY, S1_AXI_ARREADY}); end
        tick();
        S0_AXI_ARVALID = 0; M_AXI_ARREADY = 0;
        M_AXI_RDATA = 32'hDEADBEEF; M_AXI_RLAST = 1; M_AXI_RVALID = 1; S0_AXI_RREADY = 1;
        settle();
        n_cmp++; if ({S0_AXI_RVALID, S1_AXI_RVALID, M_AXI_RREADY, S0_AXI_RLAST} !== 4'b1011) begin
            n_err++; $display("FAIL sr_r_route: got %b want 1011", {S0_AXI_RVALID, S1_AXI_RVALID, M_AXI_RREADY, S0_AXI_RLAST});
        end
        n_cmp++; if (S0_AXI_RDATA !== 32'hDEADBEEF) begin n_err++; $display("FAIL sr_rdata: got %h want %h", S0_AXI_RDATA, 32'hDEADBEEF); end
        tick();
        M_AXI_RVALID = 0; M_AXI_RLAST = 0;
        settle();
        n_cmp++; if (hs_vec() !== 15'h0) begin n_err++; $display("FAIL sr_back_idle: got %h want %h", hs_vec(), 15'h0); end
        clear_inputs();
    endtask

    task automatic test_round_robin();
        do_reset();
        S0_AXI_ARADDR = 32'hA0; S1_AXI_ARADDR = 32'hB0;
        S0_AXI_ARVALID = 1; S1_AXI_ARVALID = 1; M_AXI_ARREADY = 1;
        S0_AXI_RREADY = 1; S1_AXI_RREADY = 1;
        settle();
        tick();
        n_cmp++; if ({M_AXI_ARADDR, S0_AXI_ARREADY, S1_AXI_ARREADY} !== {32'hA0, 2'b10}) begin
            n_err++; $display("FAIL rr_first_s0: got %h want %h", {M_AXI_ARADDR, S0_AXI_ARREADY, S1_AXI_ARREADY}, {32'hA0, 2'b10});
        end
        tick();
        S0_AXI_ARVALID = 0; M_AXI_RVALID = 1; M_AXI_RLAST = 1; M_AXI_RDATA = 32'h11;
        settle();
        n_cmp++; if ({S0_AXI_RVALID, S1_AXI_RVALID} !== 2'b10) begin n_err++; $display("FAIL rr_s0_data: got %b want 10", {S0_AXI_RVALID, S1_AXI_RVALID}); end
        tick();
        M_AXI_RVALID = 0;
        settle();
        n_cmp++; if ({S0_AXI_ARREADY, S1_AXI_ARREADY, M_AXI_ARVALID} !== 3'b000) begin
            n_err++; $display("FAIL rr_gap_cycle: got %b want 000", {S0_AXI_ARREADY, S1_AXI_ARREADY, M_AXI_ARVALID});
        end
        tick();
        n_cmp++; if ({M_AXI_ARADDR, S0_AXI_ARREADY, S1_AXI_ARREADY} !== {32'hB0, 2'b01}) begin
            n_err++; $display("FAIL rr_second_s1: got %h want %h", {M_AXI_ARADDR, S0_AXI_ARREADY, S1_AXI_ARREADY}, {32'hB0, 2'b01});
        end
        tick();
        S1_AXI_ARVALID = 0; M_AXI_RVALID = 1;
        settle();
        n_cmp++; if ({S0_AXI_RVALID, S1_AXI_RVALID} !== 2'b01) begin n_err++; $display("FAIL rr_s1_data: got %b want 01", {S0_AXI_RVALID, S1_AXI_RVALID}); end
        tick();
        M_AXI_RVALID = 0;
        S0_AXI_ARADDR = 32'hA4; S1_AXI_ARADDR = 32'hB4;
        S0_AXI_ARVALID = 1; S1_AXI_ARVALID = 1;
        settle();
        tick();
        n_cmp++; if (M_AXI_ARADDR !== 32'hA4) begin n_err++; $display("FAIL rr_tie_again_s0: got %h want %h", M_AXI_ARADDR, 32'hA4); end
        tick();
        clear_inputs();
        M_AXI_RVALID = 1; M_AXI_RLAST = 1; S0_AXI_RREADY = 1;
        settle();
        tick();
        clear_inputs();
    endtask

    task automatic test_burst_hold();
        do_reset();
        S1_AXI_ARADDR = 32'h3000; S1_AXI_ARLEN = 8'd3; S1_AXI_ARVALID = 1; M_AXI_ARREADY = 1;
        settle();
        tick();
        tick();
        S1_AXI_ARVALID = 0; S1_AXI_RREADY = 1;
        for (int b = 0; b < 4; b++) begin
            M_AXI_RVALID = 1; M_AXI_RLAST = (b == 3); M_AXI_RDATA = 32'h100 + b;
            if (b == 1) begin S0_AXI_ARADDR = 32'h4000; S0_AXI_ARVALID = 1; end
            settle();
            n_cmp++; if ({S1_AXI_RVALID, S1_AXI_RDATA, M_AXI_RREADY} !== {1'b1, 32'h100 + b, 1'b1}) begin
                n_err++; $display("FAIL burst_beat%0d: got %h want %h", b, {S1_AXI_RVALID, S1_AXI_RDATA, M_AXI_RREADY}, {1'b1, 32'h100 + b, 1'b1});
            end
            if (b >= 1) begin
                n_cmp++; if (S0_AXI_ARREADY !== 1'b0) begin n_err++; $display("FAIL burst_s0_blocked_beat%0d: got %b want 0", b, S0_AXI_ARREADY); end
            end
            tick();
        end
        M_AXI_RVALID = 0; M_AXI_RLAST = 0;
        settle();
        n_cmp++; if ({M_AXI_ARVALID, S0_AXI_ARREADY} !== 2'b00) begin n_err++; $display("FAIL burst_idle_after_last: got %b want 00", {M_AXI_ARVALID, S0_AXI_ARREADY}); end
        tick();
        n_cmp++; if ({M_AXI_ARADDR, S0_AXI_ARREADY} !== {32'h4000, 1'b1}) begin
            n_err++; $display("FAIL burst_s0_granted: got %h want %h", {M_AXI_ARADDR, S0_AXI_ARREADY}, {32'h4000, 1'b1});
        end
        tick();
        S0_AXI_ARVALID = 0; M_AXI_ARREADY = 0;
        M_AXI_RVALID = 1; M_AXI_RLAST = 1; S0_AXI_RREADY = 1;
        settle();
        tick();
        clear_inputs();
    endtask

    task automatic test_write_early_w();
        do_reset();
        S0_AXI_AWADDR = 32'h2000; S0_AXI_AWLEN = 8'd0; S0_AXI_AWVALID = 1;
        S0_AXI_WDATA = 32'h55AA55AA; S0_AXI_WSTRB = 4'hF; S0_AXI_WLAST = 1; S0_AXI_WVALID = 1;
        S0_AXI_BREADY = 1;
        settle();
        tick();
        M_AXI_WREADY = 1;
        settle();
        n_cmp++; if ({M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_WVALID, M_AXI_WDATA} !== {1'b1, 32'h2000, 1'b1, 32'h55AA55AA}) begin
            n_err++; $display("FAIL wr_forward: got %h want %h", {M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_WVALID, M_AXI_WDATA}, {1'b1, 32'h2000, 1'b1, 32'h55AA55AA});
        end
        n_cmp++; if ({S0_AXI_AWREADY, S0_AXI_WREADY} !== 2'b01) begin n_err++; $display("FAIL wr_w_first: got %b want 01", {S0_AXI_AWREADY, S0_AXI_WREADY}); end
        tick();
        S0_AXI_WVALID = 0; S0_AXI_WLAST = 0;
        settle();
        n_cmp++; if ({M_AXI_WVALID, M_AXI_AWVALID, M_AXI_BREADY} !== 3'b010) begin
            n_err++; $display("FAIL wr_wait_aw: got %b want 010", {M_AXI_WVALID, M_AXI_AWVALID, M_AXI_BREADY});
        end
        tick();
        M_AXI_AWREADY = 1;
        settle();
        n_cmp++; if ({S0_AXI_AWREADY, M_AXI_BREADY} !== 2'b10) begin n_err++; $display("FAIL wr_aw_late: got %b want 10", {S0_AXI_AWREADY, M_AXI_BREADY}); end
        tick();
        S0_AXI_AWVALID = 0; M_AXI_AWREADY = 0;
        M_AXI_BVALID = 1; M_AXI_BRESP = 2'b00;
        settle();
        n_cmp++; if ({S0_AXI_BVALID, S1_AXI_BVALID, S0_AXI_BRESP, M_AXI_BREADY, M_AXI_AWVALID} !== 6'b10_00_10) begin
            n_err++; $display("FAIL wr_resp: got %b want 100010", {S0_AXI_BVALID, S1_AXI_BVALID, S0_AXI_BRESP, M_AXI_BREADY, M_AXI_AWVALID});
        end
        tick();
        settle();
        n_cmp++; if (hs_vec() !== 15'h0) begin n_err++; $display("FAIL wr_back_idle: got %h want %h", hs_vec(), 15'h0); end
        clear_inputs();
    endtask

    task automatic test_concurrent();
        do_reset();
        S1_AXI_ARADDR = 32'h300; S1_AXI_ARLEN = 8'd0; S1_AXI_ARVALID = 1; S1_AXI_RREADY = 1;
        S0_AXI_AWADDR = 32'h400; S0_AXI_AWVALID = 1;
        S0_AXI_WDATA = 32'h12345678; S0_AXI_WSTRB = 4'h3; S0_AXI_WLAST = 1; S0_AXI_WVALID = 1; S0_AXI_BREADY = 1;
        M_AXI_ARREADY = 1; M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
        settle();
        n_cmp++; if (hs_vec() !== 15'h0) begin n_err++; $display("FAIL cc_arb_cycle: got %h want %h", hs_vec(), 15'h0); end
        tick();
        n_cmp++; if ({M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARADDR, M_AXI_AWADDR, M_AXI_WSTRB} !== {3'b111, 32'h300, 32'h400, 4'h3}) begin
            n_err++; $display("FAIL cc_m_active: got %h want %h", {M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARADDR, M_AXI_AWADDR, M_AXI_WSTRB}, {3'b111, 32'h300, 32'h400, 4'h3});
        end
        n_cmp++; if ({S0_AXI_ARREADY, S1_AXI_ARREADY, S0_AXI_AWREADY, S1_AXI_AWREADY, S0_AXI_WREADY, S1_AXI_WREADY} !== 6'b011010) begin
            n_err++; $display("FAIL cc_readies: got %b want 011010", {S0_AXI_ARREADY, S1_AXI_ARREADY, S0_AXI_AWREADY, S1_AXI_AWREADY, S0_AXI_WREADY, S1_AXI_WREADY});
        end
        tick();
        S1_AXI_ARVALID = 0; S0_AXI_AWVALID = 0; S0_AXI_WVALID = 0;
        M_AXI_RVALID = 1; M_AXI_RLAST = 1; M_AXI_RDATA = 32'h77;
        M_AXI_BVALID = 1; M_AXI_BRESP = 2'b10;
        settle();
        n_cmp++; if ({S0_AXI_RVALID, S1_AXI_RVALID, S0_AXI_BVALID, S1_AXI_BVALID} !== 4'b0110) begin
            n_err++; $display("FAIL cc_resp_route: got %b want 0110", {S0_AXI_RVALID, S1_AXI_RVALID, S0_AXI_BVALID, S1_AXI_BVALID});
        end
        n_cmp++; if ({S1_AXI_RDATA, S0_AXI_BRESP, S1_AXI_BRESP} !== {32'h77, 2'b10, 2'b00}) begin
            n_err++; $display("FAIL cc_resp_payload: got %h want %h", {S1_AXI_RDATA, S0_AXI_BRESP, S1_AXI_BRESP}, {32'h77, 2'b10, 2'b00});
        end
        tick();
        clear_inputs();
        settle();
        n_cmp++; if (hs_vec() !== 15'h0) begin n_err++; $display("FAIL cc_back_idle: got %h want %h", hs_vec(), 15'h0); end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        // Complete one S0 read first so that, without a reset, S1 would win
        // the next tie.
        S0_AXI_ARADDR = 32'h500; S0_AXI_ARVALID = 1; M_AXI_ARREADY = 1; S0_AXI_RREADY = 1;
        settle();
        tick();
        tick();
        S0_AXI_ARVALID = 0; M_AXI_RVALID = 1; M_AXI_RLAST = 1;
        settle();
        tick();
        M_AXI_RVALID = 0; M_AXI_RLAST = 0;
        S0_AXI_ARADDR = 32'h600; S0_AXI_ARLEN = 8'd3; S0_AXI_ARVALID = 1;
        settle();
        tick();
        tick();
        S0_AXI_ARVALID = 0; M_AXI_RVALID = 1; M_AXI_RLAST = 0;
        settle();
        n_cmp++; if (S0_AXI_RVALID !== 1'b1) begin n_err++; $display("FAIL rst_in_burst: got %b want 1", S0_AXI_RVALID); end
        tick();
        RST = 1;
        settle();
        tick();
        RST = 0;
        M_AXI_AWREADY = 1; M_AXI_WREADY = 1; M_AXI_BVALID = 1;
        S0_AXI_ARADDR = 32'h700; S1_AXI_ARADDR = 32'h800;
        S0_AXI_ARVALID = 1; S1_AXI_ARVALID = 1;
        settle();
        n_cmp++; if (hs_vec() !== 15'h0) begin n_err++; $display("FAIL rst_all_quiet: got %h want %h", hs_vec(), 15'h0); end
        tick();
        n_cmp++; if ({M_AXI_ARADDR, S0_AXI_ARREADY, S1_AXI_ARREADY} !== {32'h700, 2'b10}) begin
            n_err++; $display("FAIL rst_tie_s0: got %h want %h", {M_AXI_ARADDR, S0_AXI_ARREADY, S1_AXI_ARREADY}, {32'h700, 2'b10});
        end
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_burst_hold();
        test_write_early_w();
        test_concurrent();
        test_reset_midburst();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
